// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase accumulator slice.
package dds_pkg;

    localparam int unsigned ACC_W_DEF  = 32;
    localparam int unsigned RATE_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GLIDE
    } dds_state_t;

    // Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [RATE_W_DEF-1:0] glide_rate_t;

endpackage

// File: rtl/dds_glide_ramp.sv
// Glide ramp: holds current/target FTW and moves current toward target by an
// exponential step (|diff|>>rate, minimum 1, clamped so it never overshoots).
module dds_glide_ramp #(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned RATE_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic              jump,
    input  logic              step_en,
    input  logic [ACC_W-1:0]  freq_in,
    input  logic [RATE_W-1:0] rate_in,
    output logic [ACC_W-1:0]  cur_ftw,
    output logic              done
);

    logic [ACC_W-1:0]  tgt_ftw;
    logic [RATE_W-1:0] rate_q;
    logic              up;
    logic [ACC_W-1:0]  diff;
    logic [ACC_W-1:0]  step;
    logic [ACC_W-1:0]  cur_next;

    always_comb begin
        up   = (tgt_ftw >= cur_ftw);
        diff = up ? (tgt_ftw - cur_ftw) : (cur_ftw - tgt_ftw);
        step = diff >> rate_q;
        if (step == '0) begin
            step = ACC_W'(1);
        end
        // Only reachable when diff is 0; keeps cur_ftw parked on the target
        if (step > diff) begin
            step = diff;
        end
        done     = (step == diff);
        cur_next = up ? (cur_ftw + step) : (cur_ftw - step);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cur_ftw <= '0;
            tgt_ftw <= '0;
            rate_q  <= '0;
        end else if (load) begin
            tgt_ftw <= freq_in;
            rate_q  <= rate_in;
            if (jump) begin
                cur_ftw <= freq_in;
            end
        end else if (step_en) begin
            cur_ftw <= cur_next;
        end
    end

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase-word generator with FTW handshake, glide, hard sync and wrap pulse.
// Optional output dither enabled by defining DDS_DITHER_EN.
module dds_phase_accum
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned RATE_W   = RATE_W_DEF,
    parameter int unsigned DITHER_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ACC_W-1:0]  FREQ_IN,
    input  logic              FREQ_VALID,
    output logic              FREQ_READY,
    input  logic [RATE_W-1:0] GLIDE_RATE,
    input  logic              ENABLE,
    input  logic              SYNC,
    output logic [ACC_W-1:0]  DDS,
    output logic              WRAP,
    output logic              BUSY
);

    dds_state_t       state;
    dds_state_t       state_nxt;
    logic             accept;
    logic             jump;
    logic             glide_done;
    logic [ACC_W-1:0] cur_ftw;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] dither;

    assign FREQ_READY = (state != ST_GLIDE);
    assign BUSY       = (state == ST_GLIDE);
    assign accept     = FREQ_VALID & FREQ_READY;
    assign jump       = (GLIDE_RATE == '0) || (FREQ_IN == cur_ftw);

    dds_glide_ramp #(
        .ACC_W  (ACC_W),
        .RATE_W (RATE_W)
    ) u_ramp (
        .CLK     (CLK),
        .RESET   (RESET),
        .load    (accept),
        .jump    (jump),
        .step_en (state == ST_GLIDE),
        .freq_in (FREQ_IN),
        .rate_in (GLIDE_RATE),
        .cur_ftw (cur_ftw),
        .done    (glide_done)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (accept && !jump) begin
                    state_nxt = ST_GLIDE;
                end else begin
                    state_nxt = ENABLE ? ST_RUN : ST_IDLE;
                end
            end
            ST_GLIDE: begin
                if (glide_done) begin
                    state_nxt = ENABLE ? ST_RUN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef DDS_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lfsr <= LFSR_SEED;
        end else if (ENABLE) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign dither = {{(ACC_W-DITHER_W){1'b0}}, lfsr[DITHER_W-1:0]};
`else
    assign dither = '0;
`endif

    // Sum uses cur_ftw before this edge, so a new FTW shows up one cycle later
    assign acc_sum = {1'b0, acc} + {1'b0, cur_ftw};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc  <= '0;
            DDS  <= '0;
            WRAP <= 1'b0;
        end else if (SYNC) begin
            acc  <= '0;
            DDS  <= '0;
            WRAP <= 1'b0;
        end else if (ENABLE) begin
            acc  <= acc_sum[ACC_W-1:0];
            DDS  <= acc_sum[ACC_W-1:0] + dither;
            WRAP <= acc_sum[ACC_W];
        end else begin
            WRAP <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Scoreboard bench for dds_phase_accum: reference model pushes expected outputs,
// a monitor pops and compares one entry per clock.
module tb_dds_phase_accum;
    import dds_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] FREQ_IN = '0;
    logic        FREQ_VALID = 1'b0;
    logic        FREQ_READY;
    glide_rate_t GLIDE_RATE = '0;
    logic        ENABLE = 1'b0;
    logic        SYNC = 1'b0;
    logic [31:0] DDS;
    logic        WRAP;
    logic        BUSY;

    dds_phase_accum #(
        .ACC_W    (32),
        .RATE_W   (4),
        .DITHER_W (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FREQ_IN    (FREQ_IN),
        .FREQ_VALID (FREQ_VALID),
        .FREQ_READY (FREQ_READY),
        .GLIDE_RATE (GLIDE_RATE),
        .ENABLE     (ENABLE),
        .SYNC       (SYNC),
        .DDS        (DDS),
        .WRAP       (WRAP),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] dds;
        logic        wrap;
        logic        busy;
        logic        ready;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    longint unsigned m_phase, m_cur, m_tgt, m_out;
    int unsigned     m_rate;
    bit              m_glide, m_wrap;
    logic [15:0]     m_lfsr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cur = 0; m_tgt = 0; m_out = 0;
        m_rate = 0; m_glide = 0; m_wrap = 0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_step(input bit valid, input longint unsigned freq,
                              input int unsigned rate, input bit en, input bit sync);
        longint unsigned total, d, s;
        bit take;
        exp_t e;
        take = valid && !m_glide;
        total = m_phase + m_cur;
        if (sync) begin
            m_phase = 0; m_out = 0; m_wrap = 0;
        end else if (en) begin
            m_phase = total % 64'h1_0000_0000;
            m_wrap = (total >= 64'h1_0000_0000);
`ifdef DDS_DITHER_EN
            m_out = (m_phase + (m_lfsr % 256)) % 64'h1_0000_0000;
`else
            m_out = m_phase;
`endif
        end else begin
            m_wrap = 0;
        end
        if (en) begin
            bit lsb = m_lfsr[0];
            m_lfsr = m_lfsr >> 1;
            if (lsb) m_lfsr = m_lfsr ^ 16'hB400;
        end
        if (take) begin
            m_tgt = freq; m_rate = rate;
            if (rate == 0 || freq == m_cur) m_cur = freq;
            else m_glide = 1;
        end else if (m_glide) begin
            d = (m_tgt > m_cur) ? m_tgt - m_cur : m_cur - m_tgt;
            s = d >> m_rate;
            if (s == 0) s = 1;
            if (m_tgt > m_cur) m_cur = (m_cur + s > m_tgt) ? m_tgt : m_cur + s;
            else               m_cur = (m_cur < m_tgt + s) ? m_tgt : m_cur - s;
            if (m_cur == m_tgt) m_glide = 0;
        end
        e.dds = m_out[31:0]; e.wrap = m_wrap; e.busy = m_glide; e.ready = !m_glide;
        sbq.push_back(e);
    endtask

    task automatic cycle(input bit valid, input logic [31:0] freq, input int unsigned rate,
                         input bit en, input bit sync);
        @(negedge CLK);
        FREQ_VALID = valid; FREQ_IN = freq; GLIDE_RATE = glide_rate_t'(rate);
        ENABLE = en; SYNC = sync;
        model_step(valid, freq, rate, en, sync);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("dds",   DDS,   e.dds);
                chk("wrap",  {31'b0, WRAP},  {31'b0, e.wrap});
                chk("busy",  {31'b0, BUSY},  {31'b0, e.busy});
                chk("ready", {31'b0, FREQ_READY}, {31'b0, e.ready});
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_dds"},   DDS, 32'h0);
        chk({tag, "_wrap"},  {31'b0, WRAP}, 32'h0);
        chk({tag, "_busy"},  {31'b0, BUSY}, 32'h0);
        chk({tag, "_ready"}, {31'b0, FREQ_READY}, 32'h1);
    endtask

    initial begin : stim
        logic [31:0] f;
        model_reset();
        repeat (2) @(posedge CLK);
        #2;
        check_reset_state("reset");
        @(negedge CLK);
        RESET = 1'b1;

        // cur_ftw = 0 with ENABLE: phase constant, no wrap
        repeat (2) cycle(0, 0, 0, 1, 0);
        // Quarter-cycle FTW: 4000_0000, 8000_0000, C000_0000, 0 with wrap
        cycle(1, 32'h4000_0000, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 1, 0);

        // Glide 1 -> 0x1000 at rate 2, with a second FTW held valid throughout
        cycle(1, 32'h0000_0001, 0, 1, 0);
        cycle(1, 32'h0000_1000, 2, 1, 0);
        repeat (20) cycle(1, 32'h0000_2000, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // Sync: FTW 0x1000_0000, reach 0x7000_0000 then sync, then resume
        cycle(1, 32'h1000_0000, 0, 0, 1);
        repeat (7) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        repeat (2) cycle(0, 0, 0, 1, 0);

        // Pause for 5 cycles mid-run, then resume
        repeat (5) cycle(0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 1, 0);

        // Sync in the middle of a glide leaves the glide running
        cycle(1, 32'hF000_0000, 1, 1, 0);
        cycle(0, 0, 0, 1, 1);
        repeat (40) cycle(0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 2) f = $urandom;
            else              f = m_cur[31:0] + ($urandom % 4096);
            cycle(($urandom % 6) == 0, f, $urandom % 5, ($urandom % 8) != 0,
                  ($urandom % 40) == 0);
        end
        repeat (300) cycle(0, 0, 0, 1, 0);

        // Async reset in the middle of a glide, between clock edges
        cycle(1, 32'h0000_0010, 0, 1, 0);
        cycle(1, 32'h8000_0000, 3, 1, 0);
        repeat (3) cycle(0, 0, 0, 1, 0);
        chk("glide_busy_before_reset", {31'b0, m_glide}, 32'h1);
        @(posedge CLK);
        #3;
        FREQ_VALID = 1'b0; ENABLE = 1'b0; SYNC = 1'b0;
        RESET = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;
        cycle(1, 32'h2000_0000, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 1, 0);

        repeat (3) @(posedge CLK);
        #2;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
